// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory with a 2-deep in-order response FIFO.
module imem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    input  logic          resp_ready,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [7:0]    err_count
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] d0, d1, new_data;
    logic        e0, e1, new_err, live, push, pop;
    logic [1:0]  count;

    // live keeps req_ready low until the first edge after reset releases
    assign req_ready  = live && count != 2'd2;
    assign resp_valid = count != 2'd0;
    assign resp_data  = resp_valid ? d0 : NOP_WORD;
    assign resp_err   = resp_valid && e0;
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;
    assign new_err    = req_addr[1:0] != 2'b00 || req_addr[31:2] >= 30'(DEPTH_WORDS);
    assign new_data   = new_err ? NOP_WORD : mem[req_addr[AW+1:2]];

    always_ff @(posedge clk)
        if (load_en) mem[load_addr] <= load_data;

    // d0 is the head; it only moves on a pop or while empty, so it stays stable under backpressure
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            live      <= 1'b0;
            count     <= 2'd0;
            d0        <= NOP_WORD;
            d1        <= NOP_WORD;
            e0        <= 1'b0;
            e1        <= 1'b0;
            err_count <= 8'd0;
        end else begin
            live  <= 1'b1;
            count <= count + 2'(push) - 2'(pop);
            if (pop || count == 2'd0) begin
                d0 <= count == 2'd2 ? d1 : new_data;
                e0 <= count == 2'd2 ? e1 : new_err;
            end
            if (count == 2'd1) begin
                d1 <= new_data;
                e1 <= new_err;
            end
            if (push && new_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed fetches checked against a queue-based reference model.
module tb_imem_responder;
    logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, resp_ready = 1'b0, load_en = 1'b0;
    logic [31:0] req_addr = '0, load_data = '0;
    logic [5:0]  load_addr = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [7:0]  err_count;

    typedef struct packed {logic [31:0] data; logic err;} resp_t;
    resp_t       q[$];
    logic [31:0] mdl_mem [64];
    int          mdl_errs, checks, errors;
    bit          mdl_live;

    imem_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .resp_ready(resp_ready), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare outputs with the model, then advance the model over the coming edge
    task automatic step(input bit rv, input logic [31:0] ra, input bit rr, input bit le, input int la, input logic [31:0] ld);
        bit e, acc;
        @(negedge clk);
        req_valid = rv; req_addr = ra; resp_ready = rr; load_en = le; load_addr = 6'(la); load_data = ld;
        check("req_ready", {31'b0, req_ready}, {31'b0, mdl_live && q.size() < 2});
        check("resp_valid", {31'b0, resp_valid}, {31'b0, q.size() > 0});
        check("resp_data", resp_data, q.size() > 0 ? q[0].data : 32'h0);
        check("resp_err", {31'b0, resp_err}, {31'b0, q.size() > 0 ? q[0].err : 1'b0});
        check("err_count", {24'b0, err_count}, mdl_errs);
        acc = rv && mdl_live && q.size() < 2;
        if (q.size() > 0 && rr) void'(q.pop_front());
        if (acc) begin
            e = ra[1:0] != 2'b00 || ra[31:2] >= 64;
            q.push_back('{e ? 32'h0 : mdl_mem[ra[7:2]], e});
            if (e && mdl_errs < 255) mdl_errs++;
        end
        if (le) mdl_mem[la] = ld;
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 32'h0, rr, 1'b0, 0, 32'h0);
    endtask

    // Asynchronous low pulse placed between clock edges
    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0; load_en = 1'b0; resp_ready = 1'b0;
        #1 reset = 1'b0;
        q.delete(); mdl_errs = 0; mdl_live = 1'b0;
        #1;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        check("rst_err_count", {24'b0, err_count}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        #10 reset = 1'b1;
        #1 check("rel_req_ready", {31'b0, req_ready}, 32'h0);
        check("rel_resp_valid", {31'b0, resp_valid}, 32'h0);
        mdl_live = 1'b1;
    endtask

    initial begin
        logic [31:0] prog [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b0, 32'h0, 1'b1, 1'b1, i, i < 4 ? prog[i] : $urandom);
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, 0, 32'h0);
        repeat (2) idle(1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 0, 32'h0);
        repeat (2) idle(1'b0);
        repeat (3) idle(1'b1);
        step(1'b1, 32'h6, 1'b1, 1'b0, 0, 32'h0);
        step(1'b1, 32'h100, 1'b1, 1'b0, 0, 32'h0);
        idle(1'b1);
        check("err_count_two", {24'b0, err_count}, 32'd2);
        for (int i = 0; i < 256; i++) step(1'b1, 32'h100 + 32'($urandom_range(0, 3)), 1'b1, 1'b0, 0, 32'h0);
        repeat (2) idle(1'b1);
        check("err_count_sat", {24'b0, err_count}, 32'd255);
        step(1'b1, 32'h8, 1'b1, 1'b1, 2, 32'hDEADBEEF);
        check("old_word_head", resp_data, 32'h0);
        step(1'b1, 32'h8, 1'b1, 1'b0, 0, 32'h0);
        check("old_word_after_load", resp_data, 32'h01095020);
        idle(1'b1);
        check("new_word_after_load", resp_data, 32'hDEADBEEF);
        idle(1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a = 32'($urandom_range(0, 79)) * 4 + ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
            if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFF0;
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom);
        end
        repeat (3) idle(1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 0, 32'h20080005);
        step(1'b1, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 0, 32'h0);
        idle(1'b0);
        check("full_before_reset", {31'b0, req_ready}, 32'h0);
        do_reset();
        repeat (3) idle(1'b1);
        step(1'b1, 32'h0, 1'b1, 1'b0, 0, 32'h0);
        idle(1'b1);
        check("mem0_kept", resp_data, 32'h20080005);
        idle(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit instruction words held (power of two, 16..1024).
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, word returned on any errored fetch.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_addr  input  32  byte address of fetch (PC).
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 resp_valid  output  1  resp_data/resp_err hold a valid response.
REQ-009 resp_data  output  32  fetched instruction word.
REQ-010 resp_err  output  1  response is for a misaligned or out-of-range address.
REQ-011 resp_ready  input  1  consumer accepts the response this cycle.
REQ-012 load_en  input  1  write load_data into memory this cycle.
REQ-013 load_addr  input  log2(DEPTH_WORDS)  word index for load.
REQ-014 load_data  input  32  word to store.
REQ-015 err_count  output  8  saturating count of errored requests accepted.

Function
REQ-016 Request accepted on a rising edge where req_valid=1 and req_ready=1; response accepted where resp_valid=1 and resp_ready=1.
REQ-017 Responses held in a 2-entry FIFO; req_ready SHALL equal (count<2), from registered state only, with no combinational path from resp_ready or req_valid.
REQ-018 Latency: request accepted at edge N SHALL appear at FIFO head no earlier than the cycle after edge N; with empty FIFO, resp_valid=1 in that cycle.
REQ-019 Responses returned strictly in request order.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; sustained throughput one response per cycle with resp_ready held 1.
REQ-021 resp_valid/resp_data/resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-022 req_addr[1:0]!=0: resp_err=1, resp_data=NOP_WORD.
REQ-023 req_addr[31:2] >= DEPTH_WORDS: resp_err=1, resp_data=NOP_WORD.
REQ-024 Otherwise resp_err=0, resp_data=mem[req_addr[31:2]].
REQ-025 Load to same word as an accepted request in same cycle: response SHALL carry the old (pre-write) word; write visible from the next cycle.
REQ-026 load_en is independent of handshake state and SHALL never stall requests.
REQ-027 err_count increments by 1 per accepted errored request, saturating at 255.
REQ-028 resp_data=NOP_WORD and resp_err=0 whenever resp_valid=0.

Reset
REQ-029 reset=0 SHALL immediately clear FIFO count, resp_valid=0, resp_err=0, resp_data=NOP_WORD, err_count=0, req_ready=0 while held.
REQ-030 req_ready SHALL rise in the first cycle after reset deasserts; memory contents SHALL be preserved across reset.
REQ-031 Reset mid-operation discards all buffered and in-flight responses; none emerge after release.

Verification
REQ-032 Load mem[0..3]=32'h20080005,32'h20090003,32'h01095020,32'hAC0A0000; fetch 0,4,8,12 back-to-back, resp_ready=1 -> four responses in order, one per cycle, resp_err=0.
REQ-033 resp_ready=0, three consecutive requests -> first two accepted, req_ready=0 on third until a pop; data for 0x0 held stable.
REQ-034 Fetch 0x6 and 0x100 (DEPTH_WORDS=64) -> both resp_err=1, resp_data=0, err_count=2; then 256 more errored fetches -> err_count=255.
REQ-035 load_en to word 2 with 32'hDEADBEEF same cycle as fetch 0x8 -> old word returned; next fetch 0x8 returns 32'hDEADBEEF.
REQ-036 FIFO full, reset pulsed low 10 ns asynchronously between edges -> resp_valid drops at once, no stale response after release, mem[0] still 32'h20080005.
